// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: walks the SRAM through six march elements, compares reads against the
// expected background and logs the first mismatch. Optional macro BIST_STOP_ON_FAIL_EN ends a run at the first mismatch.
module march_bist_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 4,
    parameter int FAIL_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [DATA_W-1:0]     fail_exp,
    output logic [DATA_W-1:0]     fail_got,
    output logic [2:0]            fail_elem,
    output logic [FAIL_CNT_W-1:0] fail_cnt
);
    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ST_RD, ST_CMP, ST_WR
    } step_t;

    state_t                  state_q, state_d;
    step_t                   step_q, step_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    pass_q, pass_d;
    logic [ADDR_W-1:0]       fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]       fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0]       fail_got_q, fail_got_d;
    logic [2:0]              fail_elem_q, fail_elem_d;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    logic                    elem_down, elem_rd, elem_wr, rd_bg, wr_bg, next_down;
    logic [2:0]              elem_idx;
    state_t                  next_elem;
    logic                    last_addr, mismatch, advance;
    logic [DATA_W-1:0]       rd_word;

    // Per-element attributes: direction, read background, write background, successor.
    always_comb begin
        elem_down = 1'b0;
        elem_rd   = 1'b1;
        elem_wr   = 1'b1;
        rd_bg     = 1'b0;
        wr_bg     = 1'b0;
        elem_idx  = 3'd0;
        next_elem = S_DONE;
        case (state_q)
            S_M0: begin elem_rd = 1'b0; elem_idx = 3'd0; next_elem = S_M1; end
            S_M1: begin wr_bg = 1'b1; elem_idx = 3'd1; next_elem = S_M2; end
            S_M2: begin rd_bg = 1'b1; elem_idx = 3'd2; next_elem = S_M3; end
            S_M3: begin elem_down = 1'b1; wr_bg = 1'b1; elem_idx = 3'd3; next_elem = S_M4; end
            S_M4: begin elem_down = 1'b1; rd_bg = 1'b1; elem_idx = 3'd4; next_elem = S_M5; end
            S_M5: begin elem_wr = 1'b0; elem_idx = 3'd5; next_elem = S_DONE; end
            default: begin elem_rd = 1'b0; elem_wr = 1'b0; end
        endcase
    end

    assign next_down = (next_elem == S_M3) || (next_elem == S_M4);
    assign last_addr = elem_down ? (addr_q == '0) : (addr_q == '1);
    assign rd_word   = {DATA_W{rd_bg}};

    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign mem_we   = busy && (step_q == ST_WR);
    assign mem_addr = busy ? addr_q : '0;
    assign mem_din  = mem_we ? {DATA_W{wr_bg}} : '0;
    assign mismatch = busy && (step_q == ST_CMP) && (mem_dout != rd_word);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        fail_elem_d = fail_elem_q;
        fail_cnt_d  = fail_cnt_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_M0;
                    step_d      = ST_WR;
                    addr_d      = '0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    fail_elem_d = '0;
                    fail_cnt_d  = '0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                case (step_q)
                    ST_RD:  step_d = ST_CMP;
                    ST_CMP: begin
                        if (mismatch) begin
                            // The counter never wraps back to zero, so zero means "no capture yet".
                            if (fail_cnt_q == '0) begin
                                fail_addr_d = addr_q;
                                fail_exp_d  = rd_word;
                                fail_got_d  = mem_dout;
                                fail_elem_d = elem_idx;
                            end
                            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
                        end
                        if (elem_wr) step_d = ST_WR;
                        else         advance = 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
                        if (mismatch) begin
                            state_d = S_DONE;
                            step_d  = step_q;
                            advance = 1'b0;
                        end
`endif
                    end
                    default: advance = 1'b1;
                endcase

                if (advance) begin
                    if (last_addr) begin
                        state_d = next_elem;
                        addr_d  = next_down ? '1 : '0;
                        step_d  = ST_RD;
                    end else begin
                        addr_d  = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
                        step_d  = elem_rd ? ST_RD : ST_WR;
                    end
                end
            end
        endcase

        if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = (fail_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= ST_RD;
            addr_q      <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            fail_elem_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            fail_elem_q <= fail_elem_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;
    assign fail_elem = fail_elem_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: faulty SRAM model plus an abstract March C- reference that predicts
// every SRAM port cycle and the end-of-run status; randomized faults and start pulses.
module tb_march_bist_ctrl;
    localparam int N = 256;
`ifdef BIST_STOP_ON_FAIL_EN
    localparam int T2_CNT = 1;
    localparam int T2_LEN = 1200;
`else
    localparam int T2_CNT = 2;
    localparam int T2_LEN = 3840;
`endif

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [3:0] mem_din;
    logic [3:0] mem_dout = 4'h0;
    logic       busy, done, pass;
    logic [7:0] fail_addr;
    logic [3:0] fail_exp, fail_got;
    logic [2:0] fail_elem;
    logic [7:0] fail_cnt;

    always #5 clk = ~clk;

    march_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .FAIL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
        .fail_elem(fail_elem), .fail_cnt(fail_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Fault configuration shared by the SRAM and the reference model
    logic sa_en = 1'b0;
    int   sa_addr = 0, sa_bit = 0;
    logic sa_val = 1'b0;
    logic cf_en = 1'b0;
    int   cf_aggr = 0, cf_vict = 1, cf_bit = 0;

    function automatic logic [3:0] sa_fix(input int a, input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (sa_en && a == sa_addr) r[sa_bit] = sa_val;
        return r;
    endfunction

    function automatic logic [3:0] bit_mask(input int b);
        return 4'(1 << b);
    endfunction

    // SRAM: stuck-at applied on store; writing all-ones to the aggressor sets a victim bit
    logic [3:0] sram [N];
    always @(posedge clk) begin
        if (mem_we) begin
            sram[mem_addr] <= sa_fix(int'(mem_addr), mem_din);
            if (cf_en && int'(mem_addr) == cf_aggr && mem_din == 4'hF)
                sram[cf_vict] <= sa_fix(cf_vict, sram[cf_vict] | bit_mask(cf_bit));
        end
        mem_dout <= sram[mem_addr];
    end

    // Reference model: expected per-cycle port activity and final status of one run
    typedef struct packed { logic we; logic [7:0] addr; logic [3:0] din; } op_t;
    op_t        exp_ops [$];
    logic [3:0] mm [N];
    int         m_cnt, m_writes;
    logic [7:0] m_faddr;
    logic [3:0] m_fexp, m_fgot;
    logic [2:0] m_felem;

    task automatic build_model();
        int   rd_bg [6];
        int   wr_bg [6];
        bit   down [6];
        bit   stop;
        int   a;
        op_t  op;
        logic [3:0] ex, got;
        rd_bg = '{-1, 0, 15, 0, 15, 0};
        wr_bg = '{0, 15, 0, 15, 0, -1};
        down  = '{0, 0, 0, 1, 1, 0};
        exp_ops.delete();
        m_cnt = 0; m_writes = 0; m_faddr = 0; m_fexp = 0; m_fgot = 0; m_felem = 0;
        stop = 1'b0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                if (stop) break;
                a = down[e] ? N - 1 - k : k;
                if (rd_bg[e] >= 0) begin
                    op.we = 1'b0; op.addr = 8'(a); op.din = 4'h0;
                    exp_ops.push_back(op);
                    exp_ops.push_back(op);
                    ex  = 4'(rd_bg[e]);
                    got = mm[a];
                    if (got != ex) begin
                        if (m_cnt == 0) begin
                            m_faddr = 8'(a); m_fexp = ex; m_fgot = got; m_felem = 3'(e);
                        end
                        if (m_cnt < 255) m_cnt++;
`ifdef BIST_STOP_ON_FAIL_EN
                        stop = 1'b1;
`endif
                    end
                end
                if (!stop && wr_bg[e] >= 0) begin
                    op.we = 1'b1; op.addr = 8'(a); op.din = 4'(wr_bg[e]);
                    exp_ops.push_back(op);
                    m_writes++;
                    mm[a] = sa_fix(a, 4'(wr_bg[e]));
                    if (cf_en && a == cf_aggr && wr_bg[e] == 15)
                        mm[cf_vict] = sa_fix(cf_vict, mm[cf_vict] | bit_mask(cf_bit));
                end
            end
        end
    endtask

    // Compare process: every cycle out of reset
    int   idx = 0, wr_seen = 0, rise_cyc = 0, done_cyc = 0, runs_done = 0;
    logic busy_prev = 1'b0;
    op_t  cur_op;
    always @(negedge clk) begin
        if (rst) begin
            busy_prev = 1'b0;
            idx = 0;
        end else begin
            if (busy && !busy_prev) begin
                idx = 0; wr_seen = 0; rise_cyc = cyc;
                chk("start_clear", 64'({pass, fail_cnt, fail_addr, fail_exp, fail_got, fail_elem}), 64'(0));
            end
            if (busy) begin
                if (idx < exp_ops.size()) begin
                    cur_op = exp_ops[idx];
                    chk("sram_port", 64'({done, mem_we, mem_addr, (mem_we ? mem_din : 4'h0)}),
                        64'({1'b0, cur_op.we, cur_op.addr, cur_op.din}));
                    if (mem_we) wr_seen++;
                end else begin
                    chk("run_overrun", 64'(idx + 1), 64'(exp_ops.size()));
                end
                idx++;
            end else begin
                chk("idle_port", 64'({mem_we, mem_addr, mem_din}), 64'(0));
            end
            if (done) begin
                done_cyc = cyc;
                runs_done++;
                chk("run_len", 64'(idx), 64'(exp_ops.size()));
                chk("result", 64'({busy, pass, fail_cnt, fail_addr, fail_exp, fail_got, fail_elem}),
                    64'({1'b0, (m_cnt == 0), 8'(m_cnt), m_faddr, m_fexp, m_fgot, m_felem}));
                $display("run %0d: len=%0d pass=%0b fail_cnt=%0d fail_addr=0x%02h fail_elem=%0d exp=%h got=%h",
                         runs_done, idx, pass, fail_cnt, fail_addr, fail_elem, fail_exp, fail_got);
            end
            busy_prev = busy;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit poke);
        int k;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            k++;
            if (poke) start = (k < 3000) && ($urandom_range(0, 7) == 0);
            if (k > budget) begin
                chk("done_timeout", 64'(k), 64'(budget));
                break;
            end
        end
        start = 1'b0;
        #1;
    endtask

    task automatic set_random_faults(input int kind);
        sa_en   = kind[0];
        cf_en   = kind[1];
        sa_addr = $urandom_range(0, 255);
        sa_bit  = $urandom_range(0, 3);
        sa_val  = 1'($urandom_range(0, 1));
        cf_aggr = $urandom_range(0, 255);
        cf_vict = (cf_aggr + $urandom_range(1, 255)) % 256;
        cf_bit  = $urandom_range(0, 3);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d [3];
        int len_b;
        int k;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({busy, done, pass, mem_we, mem_addr, mem_din, fail_addr,
                                fail_exp, fail_got, fail_elem, fail_cnt}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Fault-free run with literal pins on the model
        build_model();
        chk("model_len", 64'(exp_ops.size()), 64'(3840));
        chk("model_writes", 64'(m_writes), 64'(1280));
        pulse_start();
        wait_done(5000, 1'b0);
        chk("t1_latency", 64'(done_cyc - rise_cyc), 64'(3840));
        chk("t1_writes", 64'(wr_seen), 64'(1280));
        chk("t1_status", 64'({pass, fail_cnt}), 64'({1'b1, 8'd0}));

        // Bit 2 stuck-at-0 at 0x3A
        sa_en = 1'b1; sa_addr = 'h3A; sa_bit = 2; sa_val = 1'b0;
        build_model();
        chk("t2_model", 64'({m_faddr, m_felem, m_fexp, m_fgot, 8'(m_cnt)}),
            64'({8'h3A, 3'd2, 4'hF, 4'hB, 8'(T2_CNT)}));
        pulse_start();
        wait_done(5000, 1'b0);
        chk("t2_status", 64'({pass, fail_addr, fail_elem, fail_exp, fail_got, fail_cnt}),
            64'({1'b0, 8'h3A, 3'd2, 4'hF, 4'hB, 8'(T2_CNT)}));
        chk("t2_len", 64'(done_cyc - rise_cyc), 64'(T2_LEN));

        // Coupling: w1 to 0x10 sets bit0 of 0x11
        sa_en = 1'b0; cf_en = 1'b1; cf_aggr = 'h10; cf_vict = 'h11; cf_bit = 0;
        build_model();
        chk("t3_model", 64'({m_felem, m_faddr, m_fexp, m_fgot}), 64'({3'd1, 8'h11, 4'h0, 4'h1}));
        pulse_start();
        wait_done(5000, 1'b0);
        chk("t3_status", 64'({pass, fail_elem, fail_addr, fail_exp, fail_got}),
            64'({1'b0, 3'd1, 8'h11, 4'h0, 4'h1}));

        // Reset mid-run, then a clean run
        build_model();
        pulse_start();
        repeat (998) @(negedge clk);
        chk("t4_precnt", 64'(fail_cnt), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("t4_reset", 64'({busy, done, pass, mem_we, mem_addr, mem_din, fail_addr,
                             fail_exp, fail_got, fail_elem, fail_cnt}), 64'(0));
        rst = 1'b0;
        cf_en = 1'b0;
        build_model();
        pulse_start();
        wait_done(5000, 1'b0);
        chk("t4_latency", 64'(done_cyc - rise_cyc), 64'(3840));
        chk("t4_pass", 64'(pass), 64'(1));

        // start held high: three back-to-back runs, middle one faulty
        sa_en = 1'b0; cf_en = 1'b0;
        build_model();
        len_b = 0;
        start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!done && k < 5000);
            #1;
            chk("t5_done_seen", 64'(done), 64'(1));
            d[r] = done_cyc;
            chk("t5_pass", 64'(pass), 64'(r != 1));
            if (r == 2) start = 1'b0;
            @(posedge clk);
            if (r == 0) begin
                set_random_faults(1);
                build_model();
                len_b = exp_ops.size();
            end else if (r == 1) begin
                sa_en = 1'b0;
                build_model();
            end
        end
        chk("t5_gap1", 64'(d[1] - d[0]), 64'(len_b + 2));
        chk("t5_gap2", 64'(d[2] - d[1]), 64'(3842));

        // Randomized faults with stray start pulses during the run
        for (int r = 0; r < 5; r++) begin
            set_random_faults($urandom_range(0, 3));
            build_model();
            pulse_start();
            wait_done(5000, 1'b1);
            chk("rnd_len", 64'(done_cyc - rise_cyc), 64'(exp_ops.size()));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
